// File: rtl/turn_seq_param_pkg.sv
// turn_seq_pkg: state codes and state width shared by the lamp sequencer and other lab FSMs
package turn_seq_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_e;
endpackage

// File: rtl/turn_seq_param_if.sv
// turn_seq_param_if: driver switch requests in, lamp drive and debug state out
interface turn_seq_param_if #(parameter int LAMPS = 3);
    import turn_seq_pkg::*;
    logic               L;
    logic               R;
    logic               H;
    logic [LAMPS-1:0]   lamps_l;
    logic [LAMPS-1:0]   lamps_r;
    logic [STATE_W-1:0] state;
    logic               busy;
    modport master (output L, R, H, input lamps_l, lamps_r, state, busy);
    modport slave  (input L, R, H, output lamps_l, lamps_r, state, busy);
endinterface

// File: rtl/turn_seq_param_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every DIV clocks
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic Reset,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] pc_q, pc_d;
    assign tick = pc_q == LAST;
    assign pc_d = tick ? '0 : pc_q + W'(1);
    always_ff @(posedge clk) begin
        pc_q <= Reset ? '0 : pc_d;
    end
endmodule

// File: rtl/turn_seq_param.sv
// turn_seq_param: turn/hazard lamp sequencer, LAMPS-wide sweep per side, ticked by tick_gen
module turn_seq_param
    import turn_seq_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int DIV   = 4
) (
    input logic             clk,
    input logic             Reset,
    turn_seq_param_if.slave bus
);
    localparam int KW = $clog2(LAMPS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(LAMPS);
    localparam logic [LAMPS:0] ONE = (LAMPS + 1)'(1);
    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LAMPS-1:0] ll_q, ll_d, lr_q, lr_d;
    logic [LAMPS:0]   sweep;
    logic             tick, haz;
    tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .Reset(Reset), .tick(tick));
    assign haz = bus.H | (bus.L & bus.R);
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (haz) begin
                        state_d = HAZ_ON;
                    end else if (bus.L) begin
                        state_d = LEFT;
                        k_d     = KW'(1);
                    end else if (bus.R) begin
                        state_d = RIGHT;
                        k_d     = KW'(1);
                    end
                end
                LEFT, RIGHT: begin
                    if (haz) begin
                        state_d = HAZ_ON;
                        k_d     = '0;
                    end else if (k_q < K_LAST) begin
                        k_d = k_q + KW'(1);
                    end else begin
                        state_d = IDLE;
                        k_d     = '0;
                    end
                end
                HAZ_ON:  state_d = HAZ_OFF;
                HAZ_OFF: state_d = haz ? HAZ_ON : IDLE;
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end
    // (1<<k)-1 with one spare bit so k==LAMPS yields all ones
    assign sweep = (ONE << k_d) - ONE;
    assign ll_d  = state_d == LEFT  ? sweep[LAMPS-1:0] : state_d == HAZ_ON ? '1 : '0;
    assign lr_d  = state_d == RIGHT ? sweep[LAMPS-1:0] : state_d == HAZ_ON ? '1 : '0;
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            ll_q    <= '0;
            lr_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ll_q    <= ll_d;
            lr_q    <= lr_d;
        end
    end
    assign bus.lamps_l = ll_q;
    assign bus.lamps_r = lr_q;
    assign bus.state   = state_q;
    assign bus.busy    = state_q != IDLE;
endmodule

// File: tb/tb_turn_seq_param.sv
// tb_turn_seq_param: scenario tasks plus random stimulus against a cycle-level behavioural model
module tb_turn_seq_param;
    localparam int LAMPS = 3;
    localparam int DIV   = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m_mode = 0;
    int   m_k = 0;
    int   m_pc = 0;
    turn_seq_param_if #(.LAMPS(3)) bus ();
    turn_seq_param_if #(.LAMPS(5)) bus2 ();
    turn_seq_param #(.LAMPS(3), .DIV(4)) dut (.clk(clk), .Reset(rst), .bus(bus));
    turn_seq_param #(.LAMPS(5), .DIV(1)) dut2 (.clk(clk), .Reset(rst2), .bus(bus2));
    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {bus.lamps_l, bus.lamps_r, bus.state, bus.busy};
    endfunction

    function automatic logic [9:0] expv();
        logic [2:0] l, r;
        l = m_mode == 1 ? 3'((1 << m_k) - 1) : m_mode == 3 ? 3'b111 : 3'b000;
        r = m_mode == 2 ? 3'((1 << m_k) - 1) : m_mode == 3 ? 3'b111 : 3'b000;
        return {l, r, 3'(m_mode), m_mode != 0};
    endfunction

    // advances the model by one clock using the inputs present before the edge
    task automatic step();
        logic haz, tk;
        haz = bus.H | (bus.L & bus.R);
        tk  = m_pc == DIV - 1;
        if (rst) begin
            m_mode = 0; m_k = 0; m_pc = 0;
        end else begin
            m_pc = tk ? 0 : m_pc + 1;
            if (tk) begin
                if (m_mode == 0) begin
                    if (haz) m_mode = 3;
                    else if (bus.L) begin m_mode = 1; m_k = 1; end
                    else if (bus.R) begin m_mode = 2; m_k = 1; end
                end else if (m_mode == 1 || m_mode == 2) begin
                    if (haz) begin m_mode = 3; m_k = 0; end
                    else if (m_k < LAMPS) m_k++;
                    else begin m_mode = 0; m_k = 0; end
                end else if (m_mode == 3) m_mode = 4;
                else m_mode = haz ? 3 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.L = 0; bus.R = 0; bus.H = 0;
        bus2.L = 0; bus2.R = 0; bus2.H = 0;
        step(); step();
        checks++;
        if (obs() !== 10'b0) begin errors++; $display("FAIL reset got %b exp %b", obs(), 10'b0); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        bus.L = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL mid_sweep cyc%0d got %b exp %b", i, obs(), expv()); end
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.lamps_l !== 3'b000 || bus.state !== 3'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_override got l=%b st=%0d busy=%b exp 000/0/0", bus.lamps_l, bus.state, bus.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.lamps_l !== 3'b000) begin errors++; $display("FAIL pre_first_tick cyc%0d got %b exp 000", i, bus.lamps_l); end
        end
        step();
        checks++;
        if (bus.lamps_l !== 3'b001) begin errors++; $display("FAIL first_tick got %b exp 001", bus.lamps_l); end
    endtask

    task automatic test_left_sweep();
        do_reset();
        bus.L = 1; bus.R = 0; bus.H = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL left_sweep cyc%0d got %b exp %b", i, obs(), expv()); end
        end
        bus.L = 0;
    endtask

    task automatic test_right_pulse();
        int lit;
        lit = 0;
        do_reset();
        bus.L = 0; bus.R = 0; bus.H = 0;
        while (m_pc != DIV - 1) step();
        bus.R = 1;
        step();
        bus.R = 0;
        if (bus.lamps_r != 0) lit++;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL right_pulse cyc%0d got %b exp %b", i, obs(), expv()); end
            step();
            if (bus.lamps_r != 0) lit++;
        end
        checks++;
        if (lit !== LAMPS * DIV) begin errors++; $display("FAIL right_pulse_len got %0d exp %0d", lit, LAMPS * DIV); end
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL right_pulse_idle got %0d exp 0", bus.state); end
    endtask

    task automatic test_hazard_preempt();
        int  n;
        bit  saw_off;
        do_reset();
        bus.L = 1; bus.R = 0; bus.H = 0;
        n = 0;
        while (!(m_mode == 1 && m_k == 2) && n < 50) begin step(); n++; end
        bus.H = 1;
        n = 0;
        while (m_mode != 3 && n < 20) begin
            step(); n++;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL haz_enter cyc%0d got %b exp %b", n, obs(), expv()); end
        end
        checks++;
        if (bus.lamps_l !== 3'b111 || bus.lamps_r !== 3'b111) begin
            errors++; $display("FAIL haz_on got l=%b r=%b exp 111/111", bus.lamps_l, bus.lamps_r);
        end
        for (int i = 0; i < 2 * DIV; i++) begin
            step();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL haz_blink cyc%0d got %b exp %b", i, obs(), expv()); end
        end
        bus.H = 0;
        n = 0;
        saw_off = 0;
        while (m_mode != 1 && n < 40) begin
            step(); n++;
            if (m_mode == 4) saw_off = 1;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL haz_exit cyc%0d got %b exp %b", n, obs(), expv()); end
        end
        checks++;
        if (bus.lamps_l !== 3'b001 || !saw_off) begin
            errors++; $display("FAIL haz_resume got %b off=%0d exp 001 off=1", bus.lamps_l, saw_off);
        end
        bus.L = 0;
    endtask

    task automatic test_lr_together();
        do_reset();
        bus.L = 1; bus.R = 1; bus.H = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs() !== expv() || bus.lamps_l !== bus.lamps_r) begin
                errors++; $display("FAIL lr_hazard cyc%0d got %b exp %b", i, obs(), expv());
            end
        end
        bus.L = 0; bus.R = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.L = 1'($urandom_range(0, 1));
                bus.R = 1'($urandom_range(0, 1));
                bus.H = $urandom_range(0, 3) == 0;
            end
            rst = $urandom_range(0, 99) == 0;
            step();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random cyc%0d got %b exp %b", i, obs(), expv()); end
        end
        rst = 1'b0;
    endtask

    task automatic test_div1();
        logic [4:0] e;
        int s;
        checks++;
        if (bus2.lamps_r !== 5'b0 || bus2.busy !== 1'b0) begin
            errors++; $display("FAIL div1_reset got %b exp 00000", bus2.lamps_r);
        end
        bus2.R = 1;
        rst2 = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk);
            #1;
            s = (n - 1) % 6;
            e = s < 5 ? 5'((1 << (s + 1)) - 1) : 5'b0;
            checks++;
            if (bus2.lamps_r !== e || bus2.lamps_l !== 5'b0) begin
                errors++; $display("FAIL div1_sweep cyc%0d got r=%b l=%b exp r=%b l=00000", n, bus2.lamps_r, bus2.lamps_l, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_sweep();
        test_left_sweep();
        test_right_pulse();
        test_hazard_preempt();
        test_lr_together();
        test_random();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/turn_seq_param.md
# turn_seq_param

Parametrised turn/hazard lamp sequencer: a registered FSM that replaces the combinational next-state/output pair with one clocked block. It generalises the 3-lamp-per-side sweep to `LAMPS` lamps, adds an internal tick prescaler and a hazard mode, and drives the lamp outputs directly. It sits between the debounced driver switches (`L`, `R`, `H`) and the lamp drivers.

## Interface
- `LAMPS`, default 3: lamps per side, 1..8; bit 0 is innermost.
- `DIV`, default 4: clock cycles per sequencer tick, 1..2^16.
- `clk`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `L`  in  1  left-turn request, level.
- `R`  in  1  right-turn request, level.
- `H`  in  1  hazard request, level.
- `lamps_l`  out  `LAMPS`  left lamp drive, registered.
- `lamps_r`  out  `LAMPS`  right lamp drive, registered.
- `state`  out  3  current state code, debug.
- `busy`  out  1  high whenever `state` ≠ IDLE.

## Operation
- States, 3-bit code: IDLE=0, LEFT=1, RIGHT=2, HAZ_ON=3, HAZ_OFF=4. Step counter `k`, width $clog2(LAMPS+1).
- Prescaler `pc` counts 0..DIV-1 and wraps. `tick` = (`pc`==DIV-1). With DIV=1, `tick` is asserted every cycle.
- State and `k` change only on cycles with `tick`=1. Between ticks, all registers except `pc` hold.
- Request decode on a tick uses this priority:
  - `haz` = `H` | (`L` & `R`)
  - then `L`
  - then `R`
- IDLE on a tick:
  - `haz` → HAZ_ON
  - else `L` → LEFT with k=1
  - else `R` → RIGHT with k=1
  - else stay in IDLE.
- LEFT/RIGHT on a tick:
  - `haz` → HAZ_ON (preempts the sweep).
  - else if k<LAMPS → k+1.
  - else (k==LAMPS) → IDLE with k=0. The sweep always completes; releasing `L`/`R` mid-sweep does not abort it.
- HAZ_ON → HAZ_OFF on a tick.
- HAZ_OFF on a tick:
  - `haz` → HAZ_ON
  - else → IDLE.
- A direction change (e.g. `R` asserted during LEFT) takes effect only after the current sweep returns to IDLE.
- Outputs are a registered function of the next state:
  - LEFT: `lamps_l` = (1<<k)-1, `lamps_r` = 0.
  - RIGHT: mirror of LEFT.
  - HAZ_ON: both sides all ones.
  - IDLE and HAZ_OFF: both sides all zeros.

## Timing
- Reset values: state=IDLE, k=0, pc=0, `lamps_l`=`lamps_r`=0, `state`=0, `busy`=0.
- `Reset` overrides everything, including mid-sweep and mid-hazard. Outputs are zero in the cycle after `Reset` is sampled high.
- After `Reset` deasserts, the first tick occurs DIV cycles later.
- Latency: a request that is valid on a tick cycle is visible on the lamps in the next cycle. Outputs change exactly one cycle after each tick.
- One full sweep takes LAMPS+1 ticks (LAMPS lit steps plus one dark IDLE tick) before the next sweep can start. Holding `L` therefore repeats the sweep with period (LAMPS+1)·DIV cycles.
- Hazard blink period is 2·DIV cycles with a 50 % duty cycle.
- Requests are sampled only on tick cycles. Pulses shorter than DIV cycles that miss a tick are ignored; this is intended.

## Structure
- Shared package `turn_seq_pkg` holds:
  - the state enum/localparams (IDLE..HAZ_OFF);
  - the 3-bit state width constant, shared with other lab FSMs and debug displays.
- One sub-module: `tick_gen` (parameter DIV; ports `clk`, `Reset`, `tick`), a prescaler reusable by other timed lab blocks.
- The top level contains the FSM, the step counter and the output registers.
- The prior combinational next-state file is superseded and not instantiated.

## Test plan
All scenarios use LAMPS=3, DIV=4.

1. Reset mid-sweep: `L`=1 for 10 cycles, then `Reset`=1 → next cycle `lamps_l`=000, `state`=0, `busy`=0; first tick 4 cycles after `Reset` falls.
2. Left sweep, `L` held: `lamps_l` steps 001→011→111→000, each value held 4 cycles; `lamps_r`=000 throughout; the sweep repeats with a 16-cycle period.
3. Right sweep, short pulse: `R` pulsed for exactly one tick cycle → the full 001/011/111/000 sequence appears on `lamps_r`, then IDLE persists.
4. Hazard preempts sweep: `L` held, `H` raised during k=2 → at the next tick both sides go to 111, then 000, alternating every 4 cycles. `H` dropped during HAZ_ON → after HAZ_OFF the block returns to IDLE, then resumes the left sweep at 001 while `L` is still held.
5. `L`&`R` together from IDLE → behaves identically to `H` (both sides 111/000 blink).
6. DIV=1, LAMPS=5 rebuild, `R` held → `lamps_r` = 00001, 00011, 00111, 01111, 11111, 00000 on consecutive cycles, repeating with a 6-cycle period.
